// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection and pipeline control for the 5-stage core.
// It sits on the consumer side of the ID/EX boundary and drives stall,
// flush and forwarding selects. A small FSM freezes the pipe while a
// multi-cycle MDU operation runs. A watchdog traps to ERROR if the MDU
// never answers.
// Optional feature: define HAZARD_PERF_EN to add three saturating
// performance counters (perf_lu_stalls, perf_mdu_stalls, perf_flushes).
module hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MDU_TIMEOUT = 64,
  parameter int PERF_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_redirect,
  input  logic                  ex_mdu_start,
  input  logic                  mdu_done,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_reg_write,
  input  logic                  wb_reg_write,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_m,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mdu_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]     perf_lu_stalls,
  output logic [PERF_W-1:0]     perf_mdu_stalls,
  output logic [PERF_W-1:0]     perf_flushes
`endif
);

  // The wait counter is at least 7 bits wide, and wider if the timeout needs it.
  localparam int CNT_W = ($clog2(MDU_TIMEOUT) > 7) ? $clog2(MDU_TIMEOUT) : 7;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_TIMEOUT - 1);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MDU_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;
  logic             lu_stall;     // RUN-state load-use bubble this cycle
  logic             redir_flush;  // RUN-state redirect flush this cycle

  // Select the operand source. MEM is newer than WB, so it wins. x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src);
    if (mem_reg_write && (mem_rd != X0) && (mem_rd == src)) return FWD_MEM;
    else if (wb_reg_write && (wb_rd != X0) && (wb_rd == src)) return FWD_WB;
    else return FWD_RF;
  endfunction

  // Load-use hazard: the decode instruction needs a register that the EX load has not produced yet.
  assign lu = ex_mem_read && (ex_rd != X0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  // Forwarding muxes are combinational in every state and quiet during reset.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (reset_n) begin
      fwd_a = fwd_sel(ex_rs1);
      fwd_b = fwd_sel(ex_rs2);
    end
  end

  // Next-state and control-output decode for the RUN / MDU_WAIT / ERROR FSM.
  always_comb begin
    // NOTE: every output is given a default first so no path leaves one unassigned, which would infer a latch.
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_m     = 1'b0;
    mdu_timeout = 1'b0;
    lu_stall    = 1'b0;
    redir_flush = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;

    if (!reset_n) begin
      // Clear every pipeline register while the core is held in reset.
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ex_redirect) begin
            // The wrong-path instructions in IF/ID and ID/EX are discarded.
            flush_d     = 1'b1;
            flush_e     = 1'b1;
            redir_flush = 1'b1;
          end else if (ex_mdu_start) begin
            if (!mdu_done) begin
              stall_f = 1'b1;
              stall_d = 1'b1;
              stall_e = 1'b1;
              flush_m = 1'b1;
              state_d = ST_MDU_WAIT;
              cnt_d   = '0;
            end
            // If the MDU finishes on its first cycle, nothing is held.
          end else if (lu) begin
            // The load leaves EX next cycle, so a single bubble clears the hazard.
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            flush_e  = 1'b1;
            lu_stall = 1'b1;
          end
        end

        ST_MDU_WAIT: begin
          if (mdu_done) begin
            // Leave EX/MEM enabled so it captures the MDU result this cycle.
            state_d = ST_RUN;
          end else begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
            if (cnt_q == CNT_LAST) state_d = ST_ERROR;
            else                   cnt_d   = cnt_q + 1'b1;
          end
        end

        ST_ERROR: begin
          // The core stays frozen until reset. A late mdu_done is ignored.
          stall_f     = 1'b1;
          stall_d     = 1'b1;
          stall_e     = 1'b1;
          flush_m     = 1'b1;
          mdu_timeout = 1'b1;
        end

        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and watchdog registers, with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  // Saturating event counters for load-use bubbles, MDU freeze cycles and redirect flushes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_lu_stalls  <= '0;
      perf_mdu_stalls <= '0;
      perf_flushes    <= '0;
    end else begin
      if (lu_stall && (perf_lu_stalls != PERF_MAX))
        perf_lu_stalls <= perf_lu_stalls + 1'b1;
      if (stall_e && (perf_mdu_stalls != PERF_MAX))
        perf_mdu_stalls <= perf_mdu_stalls + 1'b1;
      if (redir_flush && (perf_flushes != PERF_MAX))
        perf_flushes <= perf_flushes + 1'b1;
    end
  end
`endif

  // ex_reg_write is part of the ID/EX bundle but plays no part in hazard decisions.
  logic unused_ok;
  assign unused_ok = ex_reg_write;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and pipeline-control unit for the 5-stage core.
- It is the consumer side of the ID/EX boundary. It reads EX-stage fields (rd, rs1, rs2, load and write flags, redirect, multi-cycle start) alongside decode-stage source registers.
- It drives stall, flush and forwarding-select controls back into the IF/ID, ID/EX and EX/MEM registers.
- It owns a small FSM that freezes the pipe during multi-cycle MDU operations, with a timeout watchdog.

Parameters:
- REG_ADDR_W, 5, register-index width.
- MDU_TIMEOUT, 64, maximum MDU_WAIT cycles before the error trap; must be at least 2.
- PERF_W, 32, width of each performance counter (used only with the optional feature).

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- id_rs1, id_rs2  in  REG_ADDR_W  decode-stage source registers.
- id_use_rs1, id_use_rs2  in  1  decode instruction actually reads rs1/rs2.
- ex_rs1, ex_rs2  in  REG_ADDR_W  EX-stage source registers (ID/EX outputs).
- ex_rd  in  REG_ADDR_W  EX-stage destination.
- ex_reg_write  in  1  EX instruction writes rd.
- ex_mem_read  in  1  EX instruction is a load.
- ex_redirect  in  1  branch taken or jump resolved in EX.
- ex_mdu_start  in  1  EX instruction is a multi-cycle mul/div, first cycle.
- mdu_done  in  1  MDU result valid this cycle.
- mem_rd, wb_rd  in  REG_ADDR_W  MEM/WB destinations.
- mem_reg_write, wb_reg_write  in  1  MEM/WB write enables.
- stall_f, stall_d, stall_e  out  1  hold PC, IF/ID, ID/EX.
- flush_d, flush_e, flush_m  out  1  zero IF/ID, ID/EX, EX/MEM.
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 01 WB, 10 MEM.
- mdu_timeout  out  1  sticky watchdog error.

Behaviour:
- State register holds the FSM state: RUN, MDU_WAIT, ERROR. A 7-bit-min (clog2(MDU_TIMEOUT)) wait counter sits alongside it.
- Reset (reset_n=0 at the edge): state becomes RUN, counter 0, mdu_timeout 0.
- Outputs during any cycle with reset_n=0:
  - flush_d=1, flush_e=1, flush_m=1.
  - All stalls 0, fwd 00, mdu_timeout 0.
- Reset overrides every state, including ERROR mid-wait.
- Forwarding is combinational in every state:
  - fwd_a=10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs1.
  - Otherwise fwd_a=01 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rs1.
  - Otherwise 00. MEM has priority over WB. fwd_b is the same rule on ex_rs2.
- Load-use: lu = ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
- RUN, priority order:
  - (1) ex_redirect: flush_d=1, flush_e=1, no stalls. ex_mdu_start and lu are ignored. Next state RUN.
  - (2) ex_mdu_start: stall_f=stall_d=stall_e=1, flush_m=1. Next state MDU_WAIT, counter 0. If mdu_done is also 1 in the same cycle, stall is released: outputs as in (4), and the state stays RUN.
  - (3) lu: stall_f=1, stall_d=1, flush_e=1. Exactly one bubble per load, because the load leaves EX next cycle. Next state RUN.
  - (4) Otherwise all control outputs are 0.
- MDU_WAIT:
  - If mdu_done: all stalls 0, flush_m 0 (the EX/MEM register captures the result this cycle). Next state RUN.
  - Otherwise: stall_f=stall_d=stall_e=1, flush_m=1, counter+1.
  - If the counter equals MDU_TIMEOUT-1 and mdu_done=0: next state ERROR.
  - ex_redirect, ex_mdu_start and lu are ignored in this state.
- ERROR:
  - mdu_timeout=1.
  - stall_f=stall_d=stall_e=1, flush_m=1, held until reset.
  - mdu_done is ignored.
- Flush and stall for the same register never both assert except in the reset cycle.
- x0 is never a hazard or a forwarding source.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, three saturating PERF_W-bit counters are added, with outputs perf_lu_stalls, perf_mdu_stalls and perf_flushes:
  - perf_lu_stalls increments on RUN-state lu-stall cycles.
  - perf_mdu_stalls increments on every cycle stall_e=1 outside reset.
  - perf_flushes increments on every ex_redirect flush.
  - All three clear on reset and stick at all-ones.
- When not defined, these ports and logic do not exist; behaviour is otherwise identical.

Test Plan:
- ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle of stall_f=stall_d=flush_e=1. Next cycle (ex_mem_read=0) all controls 0.
- mem_rd=wb_rd=7, both write enables 1, ex_rs1=7 -> fwd_a=10. Drop mem_reg_write -> fwd_a=01. Set ex_rs1=0 with rd=0 matches -> fwd_a=00.
- ex_redirect=1 together with ex_mdu_start=1 and lu=1 -> flush_d=flush_e=1, no stalls, state stays RUN.
- ex_mdu_start pulse, then mdu_done after 10 cycles -> 11 stalled cycles with flush_m=1. Release occurs on the done cycle. Next instruction issues normally.
- MDU_TIMEOUT=8, ex_mdu_start, mdu_done never asserted -> mdu_timeout=1 after 8 wait cycles and stays with stalls held. Drive reset_n=0 for 1 cycle -> mdu_timeout=0, state RUN.
- With HAZARD_PERF_EN: 3 load-use stalls, 2 redirects, and one MDU op done after 4 cycles -> perf_lu_stalls=3, perf_flushes=2, perf_mdu_stalls=5 (start cycle plus 4 wait cycles).
